// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt vector read-and-clear path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package intr_pkg;

   // Completion FSM states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_CPL  = 1'b1
   } state_t;

   localparam int   VECT_W     = 32;
   localparam logic VECT_SEL_0 = 1'b0;
   localparam logic VECT_SEL_1 = 1'b1;

endpackage

// File: rtl/intr_req_fifo.sv
// Small synchronous request FIFO with full/empty flags; head entry read from the register file.
// Latency: a push into an empty FIFO becomes visible (empty=0) on the following cycle, no fall-through.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates with full/empty.
module intr_req_fifo #(
   parameter int C_DEPTH = 2,
   parameter int C_WIDTH = 9
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               push,
   input  logic [C_WIDTH-1:0] push_dat,
   input  logic               pop,
   output logic [C_WIDTH-1:0] pop_dat,
   output logic               full,
   output logic               empty
);

   localparam int             AW        = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(C_DEPTH);

   logic [C_WIDTH-1:0] mem [C_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               push_ok;
   logic               pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign pop_dat = mem[rd_ptr];

   // Storage array: written on accepted push, contents need no reset
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers and occupancy; reset discards everything queued
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/intr_vect_read_clr.sv
// Host read-and-clear front end for interrupt vectors 0/1: tagged reads in, tagged snapshots out, one clear strobe per read.
// Latency: request accept to CPL_VALID is 2 cycles minimum; one completion per 2 cycles sustained.
// Backpressure: RD_REQ_READY drops when the request FIFO is full; CPL outputs hold stable while CPL_READY is low.
module intr_vect_read_clr
   import intr_pkg::*;
#(
   parameter int C_REQ_DEPTH = 2,
   parameter int C_TAG_W     = 8,
   parameter int C_CLR_EN    = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                RD_REQ_VALID,
   output logic                RD_REQ_READY,
   input  logic                RD_REQ_SEL,
   input  logic [C_TAG_W-1:0]  RD_REQ_TAG,
   output logic                CPL_VALID,
   input  logic                CPL_READY,
   output logic [VECT_W-1:0]   CPL_DATA,
   output logic [C_TAG_W-1:0]  CPL_TAG,
   input  logic [VECT_W-1:0]   VECT_0,
   input  logic [VECT_W-1:0]   VECT_1,
   output logic                VECT_0_RST,
   output logic                VECT_1_RST,
   output logic [VECT_W-1:0]   VECT_RST,
   output logic [15:0]         RD_COUNT
);

   localparam logic CLR_ON = (C_CLR_EN != 0);

   state_t               state;
   state_t               state_nxt;
   logic                 rdy_en;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 req_push;
   logic [C_TAG_W:0]     fifo_dat;
   logic                 head_sel;
   logic [C_TAG_W-1:0]   head_tag;
   logic [VECT_W-1:0]    snap;
   logic [C_TAG_W-1:0]   tag_q;
   logic                 sel_q;
   logic                 first_q;
   logic                 cpl_done;

   // READY is held low through reset and opens on the first edge after it
   assign RD_REQ_READY = rdy_en && !fifo_full;
   assign req_push     = RD_REQ_VALID && RD_REQ_READY;
   assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
   assign cpl_done     = (state == S_CPL) && CPL_READY;
   assign head_sel     = fifo_dat[C_TAG_W];
   assign head_tag     = fifo_dat[C_TAG_W-1:0];

   intr_req_fifo #(
      .C_DEPTH (C_REQ_DEPTH),
      .C_WIDTH (C_TAG_W + 1)
   ) u_req_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push     (req_push),
      .push_dat ({RD_REQ_SEL, RD_REQ_TAG}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Request-port enable, released one cycle after reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: pop starts a completion, handshake ends it
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_nxt = S_CPL;
         S_CPL:   if (CPL_READY)   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Snapshot the selected vector and tag at pop; first_q marks the single clear cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         snap    <= '0;
         tag_q   <= '0;
         sel_q   <= VECT_SEL_0;
         first_q <= 1'b0;
      end else begin
         first_q <= fifo_pop;
         if (fifo_pop) begin
            snap  <= (head_sel == VECT_SEL_1) ? VECT_1 : VECT_0;
            tag_q <= head_tag;
            sel_q <= head_sel;
         end
      end
   end

   // Completion counter, saturating so it never wraps back to zero
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RD_COUNT <= '0;
      end else if (cpl_done && (RD_COUNT != 16'hFFFF)) begin
         RD_COUNT <= RD_COUNT + 16'd1;
      end
   end

   // FSM outputs: the clear mask is the registered snapshot, never the live vector,
   // so bits arriving after the snapshot survive for the next read
   always_comb begin
      CPL_VALID  = (state == S_CPL);
      CPL_DATA   = snap;
      CPL_TAG    = tag_q;
      VECT_0_RST = CLR_ON && first_q && (sel_q == VECT_SEL_0);
      VECT_1_RST = CLR_ON && first_q && (sel_q == VECT_SEL_1);
      VECT_RST   = '0;
      if (VECT_0_RST || VECT_1_RST) begin
         VECT_RST = snap;
      end
   end

endmodule

// File: tb/tb_intr_vect_read_clr.sv
module tb_intr_vect_read_clr;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   always #5 CLK = ~CLK;

   // Read-clear instance
   logic        a_req_valid, a_req_ready, a_req_sel;
   logic [7:0]  a_req_tag;
   logic        a_cpl_valid, a_cpl_ready;
   logic [31:0] a_cpl_data;
   logic [7:0]  a_cpl_tag;
   logic        a_v0_rst, a_v1_rst;
   logic [31:0] a_vect_rst;
   logic [15:0] a_rd_count;

   // Plain-read instance
   logic        b_req_valid, b_req_ready, b_req_sel;
   logic [7:0]  b_req_tag;
   logic        b_cpl_valid, b_cpl_ready;
   logic [31:0] b_cpl_data;
   logic [7:0]  b_cpl_tag;
   logic        b_v0_rst, b_v1_rst;
   logic [31:0] b_vect_rst;
   logic [15:0] b_rd_count;
   logic [31:0] b_v1;
   logic [31:0] b_v0;

   // Source vector model for the read-clear instance
   logic [31:0] v0, v1, set0, set1;

   int errors = 0;
   int checks = 0;
   int s0 = 0, s1 = 0, both = 0, maskbad = 0, bbad = 0;

   intr_vect_read_clr #(.C_REQ_DEPTH(2), .C_TAG_W(8), .C_CLR_EN(1)) u_dut (
      .CLK(CLK), .RST(RST),
      .RD_REQ_VALID(a_req_valid), .RD_REQ_READY(a_req_ready),
      .RD_REQ_SEL(a_req_sel), .RD_REQ_TAG(a_req_tag),
      .CPL_VALID(a_cpl_valid), .CPL_READY(a_cpl_ready),
      .CPL_DATA(a_cpl_data), .CPL_TAG(a_cpl_tag),
      .VECT_0(v0), .VECT_1(v1),
      .VECT_0_RST(a_v0_rst), .VECT_1_RST(a_v1_rst),
      .VECT_RST(a_vect_rst), .RD_COUNT(a_rd_count)
   );

   intr_vect_read_clr #(.C_REQ_DEPTH(2), .C_TAG_W(8), .C_CLR_EN(0)) u_dut_noclr (
      .CLK(CLK), .RST(RST),
      .RD_REQ_VALID(b_req_valid), .RD_REQ_READY(b_req_ready),
      .RD_REQ_SEL(b_req_sel), .RD_REQ_TAG(b_req_tag),
      .CPL_VALID(b_cpl_valid), .CPL_READY(b_cpl_ready),
      .CPL_DATA(b_cpl_data), .CPL_TAG(b_cpl_tag),
      .VECT_0(b_v0), .VECT_1(b_v1),
      .VECT_0_RST(b_v0_rst), .VECT_1_RST(b_v1_rst),
      .VECT_RST(b_vect_rst), .RD_COUNT(b_rd_count)
   );

   // Source vectors: clear on strobe using the DUT mask, OR in newly raised bits
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         v0 <= '0;
         v1 <= '0;
      end else begin
         v0 <= (v0 & ~(a_v0_rst ? a_vect_rst : 32'h0)) | set0;
         v1 <= (v1 & ~(a_v1_rst ? a_vect_rst : 32'h0)) | set1;
      end
   end

   // Strobe monitor
   always @(negedge CLK) begin
      if (a_v0_rst) s0++;
      if (a_v1_rst) s1++;
      if (a_v0_rst && a_v1_rst) both++;
      if (!a_v0_rst && !a_v1_rst && a_vect_rst != 32'h0) maskbad++;
      if (b_v0_rst || b_v1_rst || b_vect_rst != 32'h0) bbad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_bits(input logic sel, input logic [31:0] mask);
      @(negedge CLK);
      if (sel) set1 = mask; else set0 = mask;
      @(negedge CLK);
      set0 = '0;
      set1 = '0;
   endtask

   task automatic send_a(input logic sel, input logic [7:0] tag);
      int n = 0;
      @(negedge CLK);
      a_req_valid = 1'b1;
      a_req_sel   = sel;
      a_req_tag   = tag;
      while (!a_req_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("req_accept", 32'(n < 50), 32'h1);
      @(negedge CLK);
      a_req_valid = 1'b0;
   endtask

   task automatic wait_cpl_a();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!a_cpl_valid && n < 20);
      chk("cpl_wait", 32'(a_cpl_valid), 32'h1);
   endtask

   task automatic take_cpl_a(input logic [31:0] exp_data, input logic [7:0] exp_tag);
      wait_cpl_a();
      chk("cpl_data", a_cpl_data, exp_data);
      chk("cpl_tag", 32'(a_cpl_tag), 32'(exp_tag));
      a_cpl_ready = 1'b1;
      @(negedge CLK);
      a_cpl_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, b1, cnt0, vis, bb;
      a_req_valid = 0; a_req_sel = 0; a_req_tag = '0; a_cpl_ready = 0;
      b_req_valid = 0; b_req_sel = 0; b_req_tag = '0; b_cpl_ready = 0;
      b_v0 = '0; b_v1 = '0; set0 = '0; set1 = '0;

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_ready", 32'(a_req_ready), 32'h0);
      chk("rst_cpl_valid", 32'(a_cpl_valid), 32'h0);
      chk("rst_cpl_data", a_cpl_data, 32'h0);
      chk("rst_cpl_tag", 32'(a_cpl_tag), 32'h0);
      chk("rst_v0_rst", 32'(a_v0_rst), 32'h0);
      chk("rst_v1_rst", 32'(a_v1_rst), 32'h0);
      chk("rst_vect_rst", a_vect_rst, 32'h0);
      chk("rst_rd_count", 32'(a_rd_count), 32'h0);
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_ready", 32'(a_req_ready), 32'h1);
      chk("post_rst_no_strobe", 32'(s0 + s1), 32'h0);

      // Basic read-clear of VECT_0
      set_bits(1'b0, 32'h21);
      send_a(1'b0, 8'h5A);
      wait_cpl_a();
      chk("t1_data", a_cpl_data, 32'h21);
      chk("t1_tag", 32'(a_cpl_tag), 32'h5A);
      chk("t1_v0_rst", 32'(a_v0_rst), 32'h1);
      chk("t1_v1_rst", 32'(a_v1_rst), 32'h0);
      chk("t1_mask", a_vect_rst, 32'h21);
      @(negedge CLK);
      chk("t1_v0_rst_one_cycle", 32'(a_v0_rst), 32'h0);
      chk("t1_mask_cleared", a_vect_rst, 32'h0);
      a_cpl_ready = 1'b1;
      @(negedge CLK);
      a_cpl_ready = 1'b0;
      chk("t1_valid_drop", 32'(a_cpl_valid), 32'h0);
      chk("t1_rd_count", 32'(a_rd_count), 32'h1);
      chk("t1_source_cleared", v0, 32'h0);

      // Race: bit 1 raised between snapshot and strobe survives
      set_bits(1'b0, 32'h01);
      send_a(1'b0, 8'h07);
      wait_cpl_a();
      chk("t2_data", a_cpl_data, 32'h01);
      chk("t2_mask", a_vect_rst, 32'h01);
      set0 = 32'h02;
      @(negedge CLK);
      set0 = '0;
      a_cpl_ready = 1'b1;
      @(negedge CLK);
      a_cpl_ready = 1'b0;
      send_a(1'b0, 8'h08);
      take_cpl_a(32'h02, 8'h08);

      // Three queued requests with completions stalled
      set_bits(1'b0, 32'h10);
      set_bits(1'b1, 32'h200);
      b0 = s0; b1 = s1;
      send_a(1'b0, 8'h01);
      send_a(1'b1, 8'h02);
      send_a(1'b0, 8'h03);
      chk("t3_fifo_full_stall", 32'(a_req_ready), 32'h0);
      repeat (10) @(negedge CLK);
      chk("t3_stalled_s0", 32'(s0 - b0), 32'h1);
      chk("t3_stalled_s1", 32'(s1 - b1), 32'h0);
      take_cpl_a(32'h10, 8'h01);
      take_cpl_a(32'h200, 8'h02);
      take_cpl_a(32'h0, 8'h03);
      chk("t3_total_s0", 32'(s0 - b0), 32'h2);
      chk("t3_total_s1", 32'(s1 - b1), 32'h1);

      // Completion backpressure for 5 cycles
      set_bits(1'b1, 32'h5);
      cnt0 = int'(a_rd_count);
      b1 = s1;
      send_a(1'b1, 8'h33);
      wait_cpl_a();
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_data", a_cpl_data, 32'h5);
         chk("t4_hold_tag", 32'(a_cpl_tag), 32'h33);
         @(negedge CLK);
      end
      chk("t4_single_strobe", 32'(s1 - b1), 32'h1);
      chk("t4_count_hold", 32'(a_rd_count), 32'(cnt0));
      a_cpl_ready = 1'b1;
      @(negedge CLK);
      a_cpl_ready = 1'b0;
      chk("t4_count_inc", 32'(a_rd_count), 32'(cnt0 + 1));

      // Reset while in S_CPL with one request queued
      set_bits(1'b0, 32'h8);
      send_a(1'b0, 8'h11);
      send_a(1'b0, 8'h12);
      chk("t5_in_cpl", 32'(a_cpl_valid), 32'h1);
      b0 = s0 + s1;
      #1 RST = 1'b1;
      #1;
      chk("t5_async_valid_drop", 32'(a_cpl_valid), 32'h0);
      chk("t5_ready_in_rst", 32'(a_req_ready), 32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      vis = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (a_cpl_valid) vis++;
      end
      chk("t5_fifo_discarded", 32'(vis), 32'h0);
      chk("t5_no_strobe", 32'(s0 + s1 - b0), 32'h0);
      chk("t5_rd_count", 32'(a_rd_count), 32'h0);
      chk("t5_ready_after", 32'(a_req_ready), 32'h1);

      // Plain-read build: data returned, no clear
      b_v1 = 32'h3FFF_FFFF;
      bb = bbad;
      @(negedge CLK);
      b_req_valid = 1'b1; b_req_sel = 1'b1; b_req_tag = 8'h9C;
      @(negedge CLK);
      b_req_valid = 1'b0;
      vis = 0;
      while (!b_cpl_valid && vis < 20) begin
         @(negedge CLK);
         vis++;
      end
      chk("t6_cpl_valid", 32'(b_cpl_valid), 32'h1);
      chk("t6_data", b_cpl_data, 32'h3FFF_FFFF);
      chk("t6_tag", 32'(b_cpl_tag), 32'h9C);
      chk("t6_v1_rst", 32'(b_v1_rst), 32'h0);
      b_cpl_ready = 1'b1;
      @(negedge CLK);
      b_cpl_ready = 1'b0;
      chk("t6_rd_count", 32'(b_rd_count), 32'h1);
      chk("t6_no_clear", 32'(bbad - bb), 32'h0);

      // Global invariants
      chk("never_both_strobes", 32'(both), 32'h0);
      chk("mask_zero_without_strobe", 32'(maskbad), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
